// File: rtl/serial_subtractor.sv
// Bit-serial W-bit subtractor: d = a - b - bin (mod 2^W) with borrow out.
// One full-subtractor cell plus a borrow flop, LSB first, one bit per clock.
// A start/done handshake sequences each operation; one result every W+2 cycles.
module serial_subtractor #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] d,
    output logic         bout
);

    // Counter must reach W-1; ceil(log2(W+1)) bits covers W as well.
    localparam int unsigned CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    r_q, r_d;      // partial result, fills from the MSB down
    logic [W-1:0]    d_q, d_d;
    logic            br_q, br_d;
    logic            bout_q, bout_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            diff_bit;
    logic            br_next;
    logic            last_bit;

    // Full-subtractor cell on the current LSBs and the running borrow.
    always_comb begin
        diff_bit = a_q[0] ^ b_q[0] ^ br_q;
        br_next  = (~a_q[0] & b_q[0]) | (~a_q[0] & br_q) | (b_q[0] & br_q);
        last_bit = (cnt_q == CW'(W - 1));
    end

    // Next-state and datapath updates; everything holds unless the state says otherwise.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        d_d     = d_q;
        br_d    = br_q;
        bout_d  = bout_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                r_d   = {diff_bit, r_q[W-1:1]};
                br_d  = br_next;
                cnt_d = cnt_q + CW'(1);
                // Publish only the complete result so d never shows partial bits.
                if (last_bit) begin
                    d_d     = {diff_bit, r_q[W-1:1]};
                    bout_d  = br_next;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers, cleared by asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            d_q     <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            d_q     <= d_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
            cnt_q   <= cnt_d;
        end
    end

    // Status outputs decode straight from the state register, so done has no input path.
    always_comb begin
        busy = (state_q == StRun);
        done = (state_q == StDone);
        d    = d_q;
        bout = bout_q;
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (W=4): timeline-level reference model,
// per-cycle compare process, plus directed vectors with hand-computed results.
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] d;
    logic         bout;

    int vecs = 0;
    int errs = 0;
    bit chk_en = 1'b0;

    serial_subtractor #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .bout  (bout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks edges since the last accepted request.
    // An operation accepted on edge n is busy for W cycles, shows done after edge n+W,
    // and a new request can be accepted from edge n+W+2 on.
    int        edge_n = 0;
    int        acc_n = -100;
    int        m_res = 0;
    int        m_d = 0;
    int        m_bout = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_n  = -100;
            m_d    = 0;
            m_bout = 0;
        end else begin
            edge_n = edge_n + 1;
            if (edge_n - acc_n == W) begin
                m_d    = m_res % (1 << W);
                m_bout = m_res / (1 << W);
            end
            if (start && (edge_n - acc_n >= W + 2)) begin
                acc_n = edge_n;
                m_res = (int'(a) - int'(b) - int'(bin) + (1 << (W + 1))) % (1 << (W + 1));
            end
        end
    end

    function automatic int m_busy();
        return ((edge_n - acc_n) >= 0 && (edge_n - acc_n) < W) ? 1 : 0;
    endfunction

    function automatic int m_done();
        return ((edge_n - acc_n) == W) ? 1 : 0;
    endfunction

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", int'(busy), m_busy());
            check("done", int'(done), m_done());
            check("d", int'(d), m_d);
            check("bout", int'(bout), m_bout);
            if (busy && done) check("busy_and_done", 1, 0);
        end
    end

    task automatic drive(input int av, input int bv, input int binv, input bit st);
        @(posedge clk);
        #2;
        a     = W'(av);
        b     = W'(bv);
        bin   = 1'(binv);
        start = st;
    endtask

    // One handshake from idle; optionally pins latency and result to literals.
    task automatic run_op(input int av, input int bv, input int binv,
                          input bit lit, input int exp_d, input int exp_bout);
        bit seen;
        drive(av, bv, binv, 1'b1);
        @(posedge clk);             // accepting edge E0
        #2;
        start = 1'b0;
        seen = 1'b0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                if (lit) begin
                    check("latency", i, W + 1);
                    check("lit_d", int'(d), exp_d);
                    check("lit_bout", int'(bout), exp_bout);
                end
            end
        end
        if (!seen) check("done_timeout", 0, 1);
    endtask

    int done_cyc[$];

    initial begin
        // Reset held with random inputs: outputs must stay zero.
        #1 rst_n = 1'b0;
        #2 chk_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(int'($urandom_range(15)), int'($urandom_range(15)),
                  int'($urandom_range(1)), 1'($urandom_range(1)));
            #1;
            check("rst_busy", int'(busy), 0);
            check("rst_done", int'(done), 0);
        end
        drive(0, 0, 0, 1'b0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // Basic and borrow-chain vectors.
        run_op(9, 3, 0, 1'b1, 6, 0);
        run_op(3, 9, 0, 1'b1, 10, 1);
        run_op(0, 0, 1, 1'b1, 15, 1);
        run_op(5, 5, 0, 1'b1, 0, 0);
        run_op(15, 0, 1, 1'b1, 14, 0);

        // start held high with operands changing every cycle.
        for (int c = 0; c < 40; c++) begin
            drive(int'($urandom_range(15)), int'($urandom_range(15)),
                  int'($urandom_range(1)), 1'b1);
            @(negedge clk);
            if (done) done_cyc.push_back(c);
        end
        check("hs_pulses", (done_cyc.size() >= 5) ? 1 : 0, 1);
        for (int i = 1; i < done_cyc.size(); i++)
            check("hs_spacing", done_cyc[i] - done_cyc[i-1], W + 2);
        drive(0, 0, 0, 1'b0);
        repeat (8) @(posedge clk);

        // Reset two cycles into RUN aborts with no result.
        drive(12, 1, 0, 1'b1);
        @(posedge clk);
        #2 start = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_d", int'(d), 0);
        check("abort_bout", int'(bout), 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (done) check("abort_spurious_done", 1, 0);
        end
        run_op(7, 2, 0, 1'b1, 5, 0);

        // Exhaustive sweep, checked by the compare process.
        for (int av = 0; av < 16; av++)
            for (int bv = 0; bv < 16; bv++)
                for (int bn = 0; bn < 2; bn++)
                    run_op(av, bv, bn, 1'b0, 0, 0);

        repeat (4) @(posedge clk);
        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
